// File: rtl/adc_capture_if.sv
// Valid/ready sample stream from adc_capture to downstream processing.
// The master drives data/valid and observes ready.
interface adc_capture_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input  out_ready);
  modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface

// File: rtl/adc_capture.sv
// ADC input register with box-car decimation by 2^AVG_LOG2 and an output FIFO
// presented as a valid/ready stream with level and sticky overflow status.
module adc_capture #(
  parameter int DATA_W     = 8,
  parameter int AVG_LOG2   = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk_25,
  input  logic              rst_n,
  input  logic              en_adc,
  input  logic [DATA_W-1:0] ad_data,
  adc_capture_if.master     out_if,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  input  logic              clr_ovf
);
  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic [DATA_W-1:0] r_ad_q;
  logic              r_en_q;
  logic [ACC_W-1:0]  r_acc;
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

  logic [ACC_W-1:0]  w_sum;
  logic [DATA_W-1:0] w_avg;
  logic              w_last, w_push, w_pop, w_full, w_wr, w_drop, w_valid;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_ad_q <= '0;
      r_en_q <= 1'b0;
    end else begin
      r_ad_q <= ad_data;
      r_en_q <= en_adc;
    end
  end

  assign w_sum = r_acc + ACC_W'(r_ad_q);
  assign w_avg = DATA_W'(w_sum >> AVG_LOG2);

  generate
    if (AVG_LOG2 == 0) begin : g_nocnt
      assign w_last = 1'b1;
    end else begin : g_cnt
      logic [AVG_LOG2-1:0] r_blk_cnt;
      // The counter wraps to zero on its own at the end of each block.
      always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n)       r_blk_cnt <= '0;
        else if (!r_en_q) r_blk_cnt <= '0;
        else              r_blk_cnt <= r_blk_cnt + 1'b1;
      end
      assign w_last = &r_blk_cnt;
    end
  endgenerate

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n)                r_acc <= '0;
    else if (!r_en_q || w_last) r_acc <= '0;
    else                        r_acc <= w_sum;
  end

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == (ADDR_W+1)'(FIFO_DEPTH));
  assign w_push  = r_en_q & w_last;
  assign w_pop   = w_valid & out_if.out_ready;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop)       r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_25) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_avg;
  end

  assign out_if.out_valid = w_valid;
  assign out_if.out_data  = w_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_level       = r_count;
  assign overflow         = r_overflow;
endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: AVG_LOG2=2 vector table plus random run against a
// queue model, and AVG_LOG2=0 sequences for reset, overflow and full-FIFO cases.
module tb_adc_capture;
  logic clk_25 = 1'b0;
  logic rst_n  = 1'b0;
  always #20 clk_25 = ~clk_25;

  logic       en2 = 0, clr2 = 0, en0 = 0, clr0 = 0;
  logic [7:0] d2 = 0, d0 = 0;
  logic [4:0] lvl2, lvl0;
  logic       ovf2, ovf0;

  adc_capture_if #(.DATA_W(8)) if2 ();
  adc_capture_if #(.DATA_W(8)) if0 ();

  adc_capture #(.DATA_W(8), .AVG_LOG2(2), .FIFO_DEPTH(16), .ADDR_W(4)) dut2 (
    .clk_25(clk_25), .rst_n(rst_n), .en_adc(en2), .ad_data(d2), .out_if(if2),
    .fifo_level(lvl2), .overflow(ovf2), .clr_ovf(clr2));
  adc_capture #(.DATA_W(8), .AVG_LOG2(0), .FIFO_DEPTH(16), .ADDR_W(4)) dut0 (
    .clk_25(clk_25), .rst_n(rst_n), .en_adc(en0), .ad_data(d0), .out_if(if0),
    .fifo_level(lvl0), .overflow(ovf0), .clr_ovf(clr0));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  task automatic do_reset();
    en2 = 0; d2 = 0; clr2 = 0; if2.out_ready = 0;
    en0 = 0; d0 = 0; clr0 = 0; if0.out_ready = 0;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic       rdy;
    int         valid;
    int         level;
    int         data;
  } vec_t;
  vec_t tbl[18];

  int popped[$];
  int exp_seq[$];
  int mq[$];
  int blk[$];
  bit m_pen, m_ovf, m_pop, m_push, m_full;
  int m_pd, m_avg, m_sum;

  initial begin
    if2.out_ready = 0;
    if0.out_ready = 0;
    // en, data, ready | valid, level, head
    tbl[0]  = '{1, 10,  0, 0, 0, 0};
    tbl[1]  = '{1, 20,  0, 0, 0, 0};
    tbl[2]  = '{1, 30,  0, 0, 0, 0};
    tbl[3]  = '{1, 41,  0, 0, 0, 0};
    tbl[4]  = '{0, 0,   0, 1, 1, 25};
    tbl[5]  = '{0, 0,   0, 1, 1, 25};
    tbl[6]  = '{1, 200, 0, 1, 1, 25};
    tbl[7]  = '{1, 200, 0, 1, 1, 25};
    tbl[8]  = '{1, 200, 0, 1, 1, 25};
    tbl[9]  = '{0, 0,   0, 1, 1, 25};
    tbl[10] = '{1, 8,   0, 1, 1, 25};
    tbl[11] = '{1, 8,   0, 1, 1, 25};
    tbl[12] = '{1, 8,   0, 1, 1, 25};
    tbl[13] = '{1, 8,   0, 1, 1, 25};
    tbl[14] = '{0, 0,   0, 1, 2, 25};
    tbl[15] = '{0, 0,   1, 1, 1, 8};
    tbl[16] = '{0, 0,   1, 0, 0, 0};
    tbl[17] = '{0, 0,   0, 0, 0, 0};

    do_reset();
    chk("rst_valid", if2.out_valid, 0);
    chk("rst_level", lvl2, 0);
    chk("rst_ovf", ovf2, 0);
    chk("rst_data", if2.out_data, 0);

    // Averaging, latency and partial-block discard.
    for (int i = 0; i < 18; i++) begin
      en2 = tbl[i].en; d2 = tbl[i].d; if2.out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", i), if2.out_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_level", i), lvl2, tbl[i].level);
      chk($sformatf("tbl%0d_data", i), if2.out_data, tbl[i].data);
      chk($sformatf("tbl%0d_ovf", i), ovf2, 0);
    end

    // Asynchronous reset with five words buffered.
    do_reset();
    en0 = 1;
    for (int i = 1; i <= 5; i++) begin d0 = 8'(i); tick(); end
    en0 = 0; tick();
    chk("pre_rst_level", lvl0, 5);
    #5 rst_n = 0;
    #1;
    chk("async_rst_valid", if0.out_valid, 0);
    chk("async_rst_level", lvl0, 0);
    chk("async_rst_ovf", ovf0, 0);
    chk("async_rst_data", if0.out_data, 0);
    tick(); rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_valid", if0.out_valid, 0);
    end

    // Overflow: 17 pass-through samples into a 16-deep FIFO.
    en0 = 1; if0.out_ready = 0;
    for (int i = 0; i <= 16; i++) begin d0 = 8'(i); tick(); end
    en0 = 0; tick();
    chk("ovf_level", lvl0, 16);
    chk("ovf_set", ovf0, 1);
    if0.out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_pop%0d", i), if0.out_data, i);
      tick();
    end
    if0.out_ready = 0;
    chk("ovf_drained_valid", if0.out_valid, 0);
    chk("ovf_sticky", ovf0, 1);
    clr0 = 1; tick(); clr0 = 0;
    chk("ovf_cleared", ovf0, 0);

    // Clear and drop on the same edge: the set wins.
    en0 = 1;
    for (int i = 0; i <= 16; i++) begin d0 = 8'(i); tick(); end
    en0 = 0; clr0 = 1; tick(); clr0 = 0;
    chk("clr_set_collision", ovf0, 1);
    chk("collision_level", lvl0, 16);
    clr0 = 1; tick(); clr0 = 0;
    chk("collision_clr", ovf0, 0);

    // Full FIFO streaming with simultaneous push and pop.
    en0 = 1; d0 = 100; tick();
    chk("stream_pre_level", lvl0, 16);
    if0.out_ready = 1;
    for (int i = 101; i <= 132; i++) begin
      if (i <= 131) d0 = 8'(i); else en0 = 0;
      popped.push_back(int'(if0.out_data));
      tick();
      chk($sformatf("stream_level_%0d", i), lvl0, 16);
    end
    for (int i = 0; i < 16; i++) begin
      popped.push_back(int'(if0.out_data));
      tick();
    end
    if0.out_ready = 0;
    chk("stream_ovf", ovf0, 0);
    chk("stream_empty", lvl0, 0);
    for (int i = 0; i < 16; i++) exp_seq.push_back(i);
    for (int i = 100; i <= 131; i++) exp_seq.push_back(i);
    chk("stream_count", popped.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < popped.size(); i++)
      chk($sformatf("stream_word%0d", i), popped[i], exp_seq[i]);

    // Random run on the averaging instance against a queue model.
    do_reset();
    m_pen = 0; m_pd = 0; m_ovf = 0;
    mq.delete(); blk.delete();
    for (int c = 0; c < 600; c++) begin
      en2  = ($urandom_range(0, 9) < 8);
      d2   = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
      if2.out_ready = ($urandom_range(0, 9) < 3);
      clr2 = ($urandom_range(0, 19) == 0);

      m_full = (mq.size() == 16);
      m_pop  = (mq.size() != 0) && if2.out_ready;
      m_push = 0;
      if (m_pen) begin
        blk.push_back(m_pd);
        if (blk.size() == 4) begin
          m_sum = 0;
          foreach (blk[k]) m_sum += blk[k];
          m_avg = m_sum / 4;
          blk.delete();
          m_push = 1;
        end
      end else begin
        blk.delete();
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push && (!m_full || m_pop)) mq.push_back(m_avg);
      if (m_push && m_full && !m_pop) m_ovf = 1;
      else if (clr2) m_ovf = 0;
      m_pen = en2; m_pd = int'(d2);

      tick();
      chk("rnd_valid", if2.out_valid, (mq.size() != 0));
      chk("rnd_level", lvl2, mq.size());
      chk("rnd_data", if2.out_data, (mq.size() != 0) ? mq[0] : 0);
      chk("rnd_ovf", ovf2, m_ovf);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
